// File: rtl/seq_shifter_n_if.sv
// seq_shifter_n_if: request/result bundle for seq_shifter_n.
//   I     - operand, captured when a start is accepted
//   amt   - unsigned shift amount, captured with the operand
//   mode  - 00 LSL, 01 LSR, 10 ASR, 11 ROL, captured with the operand
//   start - operation request
//   O     - registered result
//   busy  - high while an operation is in flight
//   done  - one-cycle pulse when O holds a new result
// master drives the request side, slave is the shifter itself.
interface seq_shifter_n_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]         I;
    logic [$clog2(WIDTH)-1:0] amt;
    logic [1:0]               mode;
    logic                     start;
    logic [WIDTH-1:0]         O;
    logic                     busy;
    logic                     done;

    modport master (output I, amt, mode, start, input O, busy, done);
    modport slave  (input I, amt, mode, start, output O, busy, done);
endinterface

// File: rtl/seq_shifter_n.sv
// seq_shifter_n: multi-cycle barrel-free shifter. An accepted request is
// shifted by up to STEP positions per clock until the remaining count is
// zero, then the result is published on O with a one-cycle done pulse.
//   clk   - clock, rising edge
//   reset - asynchronous, active-low
//   bus   - seq_shifter_n_if slave (I, amt, mode, start in; O, busy, done out)
// WIDTH: power of two, 4..64. STEP: 1..WIDTH-1.
module seq_shifter_n #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic           clk,
    input  logic           reset,
    seq_shifter_n_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] STEP_C = CW'(STEP);

    localparam logic [1:0] M_LSL = 2'b00;
    localparam logic [1:0] M_LSR = 2'b01;
    localparam logic [1:0] M_ASR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;

    logic [CW-1:0]    step_s;
    logic [CW:0]      rol_back;
    logic [WIDTH-1:0] shifted;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
        bus.O    = o_q;
    end

    // One shift step of min(STEP, cnt) positions. The last step of an
    // operation may be shorter than STEP so cnt lands exactly on zero.
    always_comb begin
        step_s   = (cnt_q < STEP_C) ? cnt_q : STEP_C;
        // ROL complement amount; only meaningful when step_s != 0
        rol_back = (CW+1)'(WIDTH) - {1'b0, step_s};
        case (mode_q)
            M_LSL:   shifted = work_q << step_s;
            M_LSR:   shifted = work_q >> step_s;
            M_ASR:   shifted = $unsigned($signed(work_q) >>> step_s);
            default: shifted = (work_q << step_s) | (work_q >> rol_back);
        endcase
    end

    // Datapath next values
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        o_d    = o_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d = bus.I;
                    cnt_d  = bus.amt;
                    mode_d = bus.mode;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    work_d = shifted;
                    cnt_d  = cnt_q - step_s;
                end else begin
                    // Only the finished value ever reaches O
                    o_d = work_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work_q <= '0;
            cnt_q  <= '0;
            mode_q <= '0;
            o_q    <= '0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            o_q    <= o_d;
        end
    end
endmodule

// File: tb/tb_seq_shifter_n.sv
// Bench for seq_shifter_n: two instances (STEP=1 and STEP=4, WIDTH=32)
// receive identical requests; results, latency, busy length and done pulses
// are compared against a arithmetic reference of the shift rules.
module tb_seq_shifter_n;
    localparam int W = 32;
    localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROL = 2'b11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_shifter_n_if #(.WIDTH(W)) bus1();
    seq_shifter_n_if #(.WIDTH(W)) bus4();

    seq_shifter_n #(.WIDTH(W), .STEP(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    seq_shifter_n #(.WIDTH(W), .STEP(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: result of shifting i by a in one go
    function automatic logic [31:0] ref_shift(input logic [31:0] i, input int a, input logic [1:0] m);
        longint    sx;
        logic [63:0] d;
        case (m)
            LSL: return i << a;
            LSR: return i >> a;
            ASR: begin
                sx = longint'($signed(i));
                return 32'(sx >>> a);
            end
            default: begin
                d = {i, i} << a;
                return d[63:32];
            end
        endcase
    endfunction

    task automatic set_in(input logic [31:0] i, input logic [4:0] a, input logic [1:0] m, input logic s);
        bus1.I = i; bus1.amt = a; bus1.mode = m; bus1.start = s;
        bus4.I = i; bus4.amt = a; bus4.mode = m; bus4.start = s;
    endtask

    // Called at a negedge with both DUTs idle; returns at a negedge with
    // both DUTs idle again. poke re-asserts start with all-ones data while
    // the operation is in flight.
    task automatic run_op(input logic [31:0] i, input logic [4:0] a, input logic [1:0] m,
                          input bit poke, output logic [31:0] r1, output logic [31:0] r4);
        int          lat[2], busyc[2], pulses[2], exp_lat[2];
        bit          stable[2];
        logic [31:0] prev[2], res[2], o[2];
        logic        bz[2], dn[2];
        logic [31:0] exp_o;
        exp_o      = ref_shift(i, int'(a), m);
        exp_lat[0] = int'(a) + 1;
        exp_lat[1] = (int'(a) + 3) / 4 + 1;
        chk("idle_busy1", bus1.busy, 0);
        chk("idle_busy4", bus4.busy, 0);
        prev[0] = bus1.O; prev[1] = bus4.O;
        for (int k = 0; k < 2; k++) begin
            lat[k] = -1; busyc[k] = 0; pulses[k] = 0; stable[k] = 1'b1; res[k] = 'x;
        end
        set_in(i, a, m, 1'b1);
        @(posedge clk);
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            // Inputs change freely after acceptance
            set_in((poke && n == 2) ? 32'hFFFF_FFFF : $urandom, 5'($urandom), 2'($urandom),
                   (poke && n == 2));
            o[0] = bus1.O; bz[0] = bus1.busy; dn[0] = bus1.done;
            o[1] = bus4.O; bz[1] = bus4.busy; dn[1] = bus4.done;
            for (int k = 0; k < 2; k++) begin
                if (bz[k]) busyc[k]++;
                if (dn[k]) begin
                    pulses[k]++;
                    if (lat[k] < 0) begin lat[k] = n; res[k] = o[k]; end
                end
                if (lat[k] < 0 && o[k] !== prev[k]) stable[k] = 1'b0;
                if (lat[k] >= 0 && n > lat[k] && o[k] !== res[k]) stable[k] = 1'b0;
            end
            if (lat[0] >= 0 && lat[1] >= 0 && n > lat[0] && n > lat[1]) break;
        end
        bus1.start = 1'b0; bus4.start = 1'b0;
        chk("result1",  res[0], exp_o);
        chk("result4",  res[1], exp_o);
        chk("latency1", lat[0], exp_lat[0]);
        chk("latency4", lat[1], exp_lat[1]);
        chk("busylen1", busyc[0], exp_lat[0] + 1);
        chk("busylen4", busyc[1], exp_lat[1] + 1);
        chk("pulses1",  pulses[0], 1);
        chk("pulses4",  pulses[1], 1);
        chk("ohold1",   stable[0], 1);
        chk("ohold4",   stable[1], 1);
        r1 = res[0]; r4 = res[1];
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r1, r4;
        int          t1[$], t4[$];
        bit          nodone;

        reset = 1'b0;
        set_in('0, '0, '0, 1'b0);
        #2;
        chk("rst_O1", bus1.O, 0);    chk("rst_O4", bus4.O, 0);
        chk("rst_busy1", bus1.busy, 0); chk("rst_busy4", bus4.busy, 0);
        chk("rst_done1", bus1.done, 0); chk("rst_done4", bus4.done, 0);

        // First start accepted on the very first edge after release
        @(negedge clk);
        reset = 1'b1;
        run_op(32'd3782, 5'd2, LSL, 1'b0, r1, r4);
        chk("lsl3782", r1, 32'd15128);

        run_op(32'h8000_0000, 5'd4, ASR, 1'b0, r1, r4);
        chk("asr_msb", r1, 32'hF800_0000);
        run_op(32'h8000_0000, 5'd4, LSR, 1'b0, r1, r4);
        chk("lsr_msb", r1, 32'h0800_0000);

        run_op(32'h8000_0001, 5'd31, ROL, 1'b0, r1, r4);
        chk("rol31", r4, 32'hC000_0000);

        for (int m = 0; m < 4; m++) begin
            run_op(32'h1234_5678, 5'd0, 2'(m), 1'b0, r1, r4);
            chk("amt0", r1, 32'h1234_5678);
        end

        // Max amount in every mode
        for (int m = 0; m < 4; m++) run_op(32'hA5C3_0F81, 5'd31, 2'(m), 1'b0, r1, r4);

        // Start during SHIFT is ignored
        run_op(32'd1, 5'd8, LSL, 1'b1, r1, r4);
        chk("ign_start1", r1, 32'h0000_0100);
        chk("ign_start4", r4, 32'h0000_0100);

        for (int t = 0; t < 40; t++)
            run_op($urandom, 5'($urandom), 2'($urandom), 1'b0, r1, r4);

        // Back-to-back with start held high
        set_in(32'h0000_00F0, 5'd3, LSR, 1'b1);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus1.done) begin t1.push_back(n); chk("b2b_o1", bus1.O, 32'h1E); end
            if (bus4.done) begin t4.push_back(n); chk("b2b_o4", bus4.O, 32'h1E); end
        end
        set_in('0, '0, '0, 1'b0);
        chk("b2b_cnt1", (t1.size() >= 3), 1);
        chk("b2b_cnt4", (t4.size() >= 3), 1);
        if (t1.size() >= 3) begin
            chk("b2b_per1a", t1[1] - t1[0], 6);
            chk("b2b_per1b", t1[2] - t1[1], 6);
        end
        if (t4.size() >= 3) begin
            chk("b2b_per4a", t4[1] - t4[0], 4);
            chk("b2b_per4b", t4[2] - t4[1], 4);
        end
        repeat (12) @(negedge clk);

        // Asynchronous reset mid-SHIFT
        set_in(32'd1, 5'd8, LSL, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_in('0, '0, '0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_O1", bus1.O, 0);       chk("arst_O4", bus4.O, 0);
        chk("arst_busy1", bus1.busy, 0); chk("arst_busy4", bus4.busy, 0);
        nodone = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus1.done || bus4.done) nodone = 1'b0;
        end
        chk("arst_nodone", nodone, 1);
        reset = 1'b1;
        run_op(32'd5, 5'd1, LSL, 1'b0, r1, r4);
        chk("post_rst", r1, 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_shifter_n.md
SEQ_SHIFTER_N -- requirements
Module: seq_shifter_n

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits; legal values are powers of two, 4 to 64.
REQ-002 Parameter STEP, default 1: maximum bit positions shifted per cycle; legal range is 1 to WIDTH-1.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port I, input, WIDTH bits: operand, sampled only when a start is accepted.
REQ-006 Port amt, input, clog2(WIDTH) bits: shift amount, unsigned, sampled only when a start is accepted.
REQ-007 Port mode, input, 2 bits: operation select (00 LSL, 01 LSR, 10 ASR, 11 ROL), sampled only when a start is accepted.
REQ-008 Port start, input, 1 bit: operation request.
REQ-009 Port O, output, WIDTH bits: registered result.
REQ-010 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 Port done, output, 1 bit: single-cycle pulse indicating that O holds a new result.

Function
REQ-012 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, a clock edge SHALL capture I into the work register, amt into the counter cnt and mode into the mode register, then go to SHIFT.
REQ-014 In SHIFT with cnt!=0, each edge SHALL shift the work register by s=min(STEP,cnt) positions per the latched mode, set cnt to cnt-s, and remain in SHIFT.
REQ-015 In SHIFT with cnt==0, the edge SHALL copy the work register to O and go to DONE.
REQ-016 In DONE, done SHALL be 1; the next edge SHALL return to IDLE unconditionally.
REQ-017 Latency SHALL be exactly ceil(amt/STEP)+1 cycles from the accepting edge to the first cycle with done=1; for amt=0 this is 1 cycle, and O equals I.
REQ-018 Shift modes:
- LSL: zero-fill from the LSB.
- LSR: zero-fill from the MSB.
- ASR: replicate the MSB.
- ROL: bits leaving the MSB re-enter at the LSB.
REQ-019 Bits shifted out SHALL be discarded, except in ROL; no carry or overflow output exists.
REQ-020 start SHALL be ignored in SHIFT and DONE, and I, amt and mode changes after acceptance SHALL NOT affect the result.
REQ-021 start held high SHALL launch a new operation on the first IDLE cycle after DONE, giving back-to-back throughput of one result per ceil(amt/STEP)+3 cycles.
REQ-022 O SHALL hold its last value outside the DONE-entry edge and SHALL NOT expose intermediate shift values.
REQ-023 The maximum amt=WIDTH-1 SHALL complete without counter underflow.
REQ-024 The result SHALL equal the combinational single-step shift of I by amt for every mode, WIDTH and STEP.

Reset
REQ-025 While reset=0, the block SHALL force the state to IDLE and set O=0, busy=0, done=0, cnt=0 and the work register to 0 immediately, without waiting for a clock.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse, and O SHALL read 0.
REQ-027 The first start SHALL be accepted on the first rising edge on which reset=1 and start=1.

Verification
REQ-028 WIDTH=32, STEP=1; I=3782, amt=2, mode=LSL -> done 3 cycles after acceptance, O=15128 (=3782*4).
REQ-029 WIDTH=32, STEP=1; I=0x80000000, amt=4, mode=ASR -> O=0xF8000000; same with mode=LSR -> O=0x08000000.
REQ-030 WIDTH=32, STEP=4; I=0x80000001, amt=31, mode=ROL -> done 9 cycles after acceptance, O=0xC0000000.
REQ-031 amt=0, any mode, I=0x12345678 -> done 1 cycle after acceptance, O=0x12345678; busy high for exactly 2 cycles.
REQ-032 Start a LSL of I=1 by amt=8 and, during SHIFT, pulse start with I=0xFFFFFFFF -> second request ignored, O=0x00000100.
REQ-033 Assert reset=0 asynchronously mid-SHIFT -> O=0 and busy=0 immediately, no done pulse; after release, a new LSL of I=5 by 1 gives O=10.
